axi_burst_sram_slave: RTL and testbench
=======================================

Name: axi_burst_sram_slave

Overview:
- Parametrised AXI4 slave memory model replacing the fixed 64-bit single-mode SRAM model behind the CPU master port in the simulation top.
- Independent read and write engines, one outstanding transaction per direction, with FIXED/INCR/WRAP bursts.
- Supports narrow transfers, configurable read latency, and address-range error responses.
- Storage is an internal word array.

Parameters:
- DATA_W, 64, data bus width in bits (32/64/128).
- ADDR_W, 32, address width.
- ID_W, 4, AXI ID width.
- DEPTH, 4096, number of DATA_W-bit words.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- RD_LAT, 1, cycles from AR handshake to first rvalid (≥1).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- awvalid/awready  in/out  1  write address handshake
- awid  in  ID_W  write ID
- awaddr  in  ADDR_W  write byte address
- awlen  in  8  beats-1
- awsize  in  3  log2 bytes per beat
- awburst  in  2  00 FIXED, 01 INCR, 10 WRAP
- wvalid/wready  in/out  1  write data handshake
- wdata  in  DATA_W  write data
- wstrb  in  DATA_W/8  byte enables
- wlast  in  1  last write beat
- bvalid/bready  out/in  1  write response handshake
- bid  out  ID_W  echoed awid
- bresp  out  2  write response
- arvalid/arready  in/out  1  read address handshake
- arid, araddr, arlen, arsize, arburst  in  ID_W, ADDR_W, 8, 3, 2  read request, same encoding as AW
- rvalid/rready  out/in  1  read data handshake
- rid  out  ID_W  echoed arid
- rdata  out  DATA_W  read data
- rresp  out  2  read response
- rlast  out  1  last read beat

Behaviour:
- Reset (sampled on clock edge while reset=1):
  - All outputs 0, FSMs to IDLE, memory contents untouched.
  - awready/arready rise the first cycle after reset deasserts.
  - Reset mid-burst aborts the burst with no response.
- Word index = (addr-BASE_ADDR)>>log2(DATA_W/8). An address outside [BASE_ADDR, BASE_ADDR+DEPTH*DATA_W/8) is out of range.
- Beat address:
  - FIXED: constant.
  - INCR: +(1<<size) per beat.
  - WRAP: wraps within an aligned (len+1)*(1<<size) window.
  - WRAP with len not in {1,3,7,15}, or size > log2(DATA_W/8): whole burst flagged SLVERR (2'b10).
- Read FSM R_IDLE → R_WAIT → R_DATA → R_IDLE:
  - R_IDLE: arready=1. On arvalid&arready, latch id/addr/len/size/burst and go to R_WAIT with counter=RD_LAT-1. If RD_LAT=1, go straight to R_DATA next cycle.
  - R_DATA: rvalid=1; rdata/rresp/rid/rlast stable until rready. On rvalid&rready advance the beat. rlast=1 on beat==len. After the last handshake return to R_IDLE (arready=1 next cycle).
  - Out-of-range beat: rdata=0, rresp=DECERR 2'b11; other beats in the burst keep OKAY.
  - rdata is always the full aligned word; narrow data sits in its natural byte lanes.
- Write FSM W_IDLE → W_DATA → W_RESP → W_IDLE:
  - W_IDLE: awready=1; latch on handshake.
  - W_DATA: wready=1. Each wvalid&wready writes the bytes where wstrb=1, provided the address is in range.
  - Burst ends on the beat with wlast=1. If wlast beat count ≠ awlen+1, bresp=SLVERR. A missing wlast after awlen+1 beats also ends the burst with SLVERR.
  - Any out-of-range beat: bresp=DECERR, which takes precedence over SLVERR. Out-of-range writes are dropped.
  - W_RESP: bvalid=1, bid=latched awid, held until bready.
- W data arriving before the AW handshake is not accepted: wready=0 outside W_DATA.
- Simultaneous read and write to the same word in the same cycle: the read returns the old data; the write lands at the clock edge.
- Burst length up to 256 beats. INCR address may cross a word boundary freely, with no 4 KB check.

Test Plan:
- Reset held 3 cycles with arvalid=1 → all outputs 0 during reset; arready=1 the first cycle after; AR accepted that cycle.
- INCR write awaddr=0x80000000, len=3, size=3, data 0x11..,0x22..,0x33..,0x44.., wstrb=0xFF; then INCR read of the same → 4 beats in order, rlast only on beat 4, bresp=rresp=0, RD_LAT=3 gives first rvalid 3 cycles after the AR handshake.
- WRAP read araddr=0x80000010, len=3, size=3 → word order 2,3,0,1; same with len=2 → all beats rresp=2'b10.
- Narrow write size=0 to 0x80000003 with wdata byte lane 3=0xAB, wstrb=0x08 → only byte 3 changes; a 64-bit read-back shows 0xAB at bits [31:24].
- Read at BASE_ADDR+DEPTH*8 → rdata=0, rresp=2'b11; write there → bresp=2'b11, memory unchanged.
- rready toggled every other cycle during a 4-beat read, bready held low 5 cycles → rdata/rlast/bvalid stable while stalled, no beat lost or duplicated, no new AW accepted until B completes.

Source files
------------

// File: rtl/axi_burst_sram_slave.sv
// AXI4 slave SRAM model: independent read/write engines, one transaction per
// direction, FIXED/INCR/WRAP bursts, narrow transfers, programmable read latency.
//
// state  | meaning
// R_IDLE | arready=1, waiting for a read request
// R_WAIT | read latency countdown
// R_DATA | rvalid=1, presenting the current read beat
// W_IDLE | awready=1, waiting for a write request
// W_DATA | wready=1, accepting write beats
// W_RESP | bvalid=1, holding the write response until bready
module axi_burst_sram_slave #(
   parameter int                DATA_W    = 64,
   parameter int                ADDR_W    = 32,
   parameter int                ID_W      = 4,
   parameter int                DEPTH     = 4096,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
   parameter int                RD_LAT    = 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                awvalid,
   output logic                awready,
   input  logic [ID_W-1:0]     awid,
   input  logic [ADDR_W-1:0]   awaddr,
   input  logic [7:0]          awlen,
   input  logic [2:0]          awsize,
   input  logic [1:0]          awburst,
   input  logic                wvalid,
   output logic                wready,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic                wlast,
   output logic                bvalid,
   input  logic                bready,
   output logic [ID_W-1:0]     bid,
   output logic [1:0]          bresp,
   input  logic                arvalid,
   output logic                arready,
   input  logic [ID_W-1:0]     arid,
   input  logic [ADDR_W-1:0]   araddr,
   input  logic [7:0]          arlen,
   input  logic [2:0]          arsize,
   input  logic [1:0]          arburst,
   output logic                rvalid,
   input  logic                rready,
   output logic [ID_W-1:0]     rid,
   output logic [DATA_W-1:0]   rdata,
   output logic [1:0]          rresp,
   output logic                rlast
);
   localparam int STRB_W = DATA_W / 8;
   localparam int LOG2_B = $clog2(STRB_W);
   localparam int IDX_W  = $clog2(DEPTH);
   localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH * STRB_W);

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] off;
      off = a - BASE_ADDR;
      return (a >= BASE_ADDR) && ({1'b0, off} < SPAN);
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
      return IDX_W'((a - BASE_ADDR) >> LOG2_B);
   endfunction

   // WRAP needs a power-of-two beat count of 2..16 and a beat no wider than the bus
   function automatic logic bad_burst(input logic [7:0] len, input logic [2:0] size,
                                      input logic [1:0] burst);
      return (burst == 2'b10) &&
             (!(len inside {8'd1, 8'd3, 8'd7, 8'd15}) || (int'(size) > LOG2_B));
   endfunction

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                   input logic [7:0] len,
                                                   input logic [2:0] size,
                                                   input logic [1:0] burst);
      logic [ADDR_W-1:0] step;
      logic [ADDR_W-1:0] wmask;
      step  = ADDR_W'(1) << size;
      wmask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
      case (burst)
         2'b00:   return a;
         2'b10:   return (a & ~wmask) | ((a + step) & wmask);
         default: return a + step;
      endcase
   endfunction

   logic [DATA_W-1:0] mem_q [DEPTH];

   r_state_t          r_state_q, r_state_d;
   logic [ID_W-1:0]   rid_q, rid_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic [7:0]        rlen_q, rlen_d, rbeat_q, rbeat_d, rcnt_q, rcnt_d;
   logic [2:0]        rsize_q, rsize_d;
   logic [1:0]        rburst_q, rburst_d, rresp_q, rresp_d;
   logic              rbad_q, rbad_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rd_load, rd_bad;
   logic [ADDR_W-1:0] rd_addr;

   w_state_t          w_state_q, w_state_d;
   logic [ID_W-1:0]   wid_q, wid_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [7:0]        wlen_q, wlen_d, wbeat_q, wbeat_d;
   logic [2:0]        wsize_q, wsize_d;
   logic [1:0]        wburst_q, wburst_d, bresp_q, bresp_d;
   logic              wbad_q, wbad_d, wdec_q, wdec_d;
   logic              mem_we, w_oor, w_end;

   assign arready = (r_state_q == R_IDLE) && !reset;
   assign rvalid  = (r_state_q == R_DATA);
   assign rlast   = rvalid && (rbeat_q == rlen_q);
   assign rid     = rid_q;
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;
   assign awready = (w_state_q == W_IDLE) && !reset;
   assign wready  = (w_state_q == W_DATA);
   assign bvalid  = (w_state_q == W_RESP);
   assign bid     = wid_q;
   assign bresp   = bresp_q;

   // Read engine next state; beat data is captured from the array when a beat is loaded
   always_comb begin
      r_state_d = r_state_q;
      rid_d     = rid_q;
      raddr_d   = raddr_q;
      rlen_d    = rlen_q;
      rsize_d   = rsize_q;
      rburst_d  = rburst_q;
      rbad_d    = rbad_q;
      rbeat_d   = rbeat_q;
      rcnt_d    = rcnt_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      rd_load   = 1'b0;
      rd_addr   = raddr_q;
      rd_bad    = rbad_q;
      case (r_state_q)
         R_IDLE: begin
            if (arvalid && arready) begin
               rid_d    = arid;
               raddr_d  = araddr;
               rlen_d   = arlen;
               rsize_d  = arsize;
               rburst_d = arburst;
               rbad_d   = bad_burst(arlen, arsize, arburst);
               rbeat_d  = 8'd0;
               if (RD_LAT <= 1) begin
                  r_state_d = R_DATA;
                  rd_load   = 1'b1;
                  rd_addr   = araddr;
                  rd_bad    = bad_burst(arlen, arsize, arburst);
               end else begin
                  r_state_d = R_WAIT;
                  rcnt_d    = 8'(RD_LAT - 1);
               end
            end
         end
         R_WAIT: begin
            if (rcnt_q == 8'd0) begin
               r_state_d = R_DATA;
               rd_load   = 1'b1;
            end else begin
               rcnt_d = rcnt_q - 8'd1;
            end
         end
         R_DATA: begin
            if (rready) begin
               if (rbeat_q == rlen_q) begin
                  r_state_d = R_IDLE;
               end else begin
                  raddr_d = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
                  rbeat_d = rbeat_q + 8'd1;
                  rd_load = 1'b1;
                  rd_addr = raddr_d;
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      if (rd_load) begin
         if (!in_range(rd_addr)) begin
            rdata_d = '0;
            rresp_d = 2'b11;
         end else begin
            rdata_d = mem_q[word_idx(rd_addr)];
            rresp_d = rd_bad ? 2'b10 : 2'b00;
         end
      end
   end

   // Write engine next state; DECERR outranks SLVERR in the final response
   always_comb begin
      w_state_d = w_state_q;
      wid_d     = wid_q;
      waddr_d   = waddr_q;
      wlen_d    = wlen_q;
      wsize_d   = wsize_q;
      wburst_d  = wburst_q;
      wbad_d    = wbad_q;
      wdec_d    = wdec_q;
      wbeat_d   = wbeat_q;
      bresp_d   = bresp_q;
      mem_we    = 1'b0;
      w_oor     = !in_range(waddr_q);
      w_end     = wlast || (wbeat_q == wlen_q);
      case (w_state_q)
         W_IDLE: begin
            if (awvalid && awready) begin
               wid_d     = awid;
               waddr_d   = awaddr;
               wlen_d    = awlen;
               wsize_d   = awsize;
               wburst_d  = awburst;
               wbad_d    = bad_burst(awlen, awsize, awburst);
               wdec_d    = 1'b0;
               wbeat_d   = 8'd0;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (wvalid) begin
               mem_we = !w_oor;
               wdec_d = wdec_q || w_oor;
               if (w_end) begin
                  w_state_d = W_RESP;
                  if (wdec_d)
                     bresp_d = 2'b11;
                  else if (wbad_q || (wlast != (wbeat_q == wlen_q)))
                     bresp_d = 2'b10;
                  else
                     bresp_d = 2'b00;
               end else begin
                  wbeat_d = wbeat_q + 8'd1;
                  waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
               end
            end
         end
         W_RESP: begin
            if (bready) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Engine registers; reset returns both engines to idle and drops any burst
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state_q <= R_IDLE;
         rid_q     <= '0;
         raddr_q   <= '0;
         rlen_q    <= '0;
         rsize_q   <= '0;
         rburst_q  <= '0;
         rbad_q    <= 1'b0;
         rbeat_q   <= '0;
         rcnt_q    <= '0;
         rdata_q   <= '0;
         rresp_q   <= '0;
         w_state_q <= W_IDLE;
         wid_q     <= '0;
         waddr_q   <= '0;
         wlen_q    <= '0;
         wsize_q   <= '0;
         wburst_q  <= '0;
         wbad_q    <= 1'b0;
         wdec_q    <= 1'b0;
         wbeat_q   <= '0;
         bresp_q   <= '0;
      end else begin
         r_state_q <= r_state_d;
         rid_q     <= rid_d;
         raddr_q   <= raddr_d;
         rlen_q    <= rlen_d;
         rsize_q   <= rsize_d;
         rburst_q  <= rburst_d;
         rbad_q    <= rbad_d;
         rbeat_q   <= rbeat_d;
         rcnt_q    <= rcnt_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         w_state_q <= w_state_d;
         wid_q     <= wid_d;
         waddr_q   <= waddr_d;
         wlen_q    <= wlen_d;
         wsize_q   <= wsize_d;
         wburst_q  <= wburst_d;
         wbad_q    <= wbad_d;
         wdec_q    <= wdec_d;
         wbeat_q   <= wbeat_d;
         bresp_q   <= bresp_d;
      end
   end

   // Byte-masked array write; contents survive reset
   always_ff @(posedge clock) begin
      if (mem_we && !reset) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (wstrb[i]) mem_q[word_idx(waddr_q)][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end
endmodule

// File: tb/tb_axi_burst_sram_slave.sv
// Self-checking bench for axi_burst_sram_slave (64-bit bus, RD_LAT=3).
module tb_axi_burst_sram_slave;
   localparam int          DW     = 64;
   localparam int          DEPTH  = 4096;
   localparam int          RD_LAT = 3;
   localparam int          TMO    = 200;
   localparam logic [31:0] BASE   = 32'h8000_0000;

   logic        clock = 1'b0;
   logic        reset;
   logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic [3:0]  awid, bid, arid, rid;
   logic [31:0] awaddr, araddr;
   logic [7:0]  awlen, arlen, wstrb;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic [63:0] wdata, rdata;
   logic        arvalid, arready, rvalid, rready, rlast;

   axi_burst_sram_slave #(.DATA_W(DW), .ADDR_W(32), .ID_W(4), .DEPTH(DEPTH),
                          .BASE_ADDR(BASE), .RD_LAT(RD_LAT)) dut (
      .clock(clock), .reset(reset),
      .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
      .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
      .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata),
      .rresp(rresp), .rlast(rlast));

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   logic [63:0] model [DEPTH];
   bit          known [DEPTH];
   logic [63:0] wbuf  [16];

   typedef struct packed {
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
      logic        dc;
      logic [3:0]  id;
   } rexp_t;
   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } bexp_t;
   rexp_t rq[$];
   bexp_t bq[$];

   function automatic longint unsigned beat_addr(input longint unsigned a, input int len,
                                                 input int size, input logic [1:0] burst,
                                                 input int i);
      longint unsigned nb, wb, base;
      nb = longint'(1) << size;
      if (burst == 2'b00) return a;
      if (burst == 2'b10) begin
         wb   = longint'(len + 1) * nb;
         base = a - (a % wb);
         return base + ((a - base) + longint'(i) * nb) % wb;
      end
      return a + longint'(i) * nb;
   endfunction

   function automatic bit oor(input longint unsigned a);
      return (a < longint'(BASE)) || (a >= longint'(BASE) + longint'(DEPTH) * 8);
   endfunction

   function automatic bit wrap_bad(input int len, input int size, input logic [1:0] burst);
      return (burst == 2'b10) && (!(len == 1 || len == 3 || len == 7 || len == 15) || size > 3);
   endfunction

   task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input logic [1:0] burst, input bit toggle,
                          input bit skip_ar);
      rexp_t           e;
      longint unsigned ba;
      int              widx, hs, t, got;
      bit              first, pstall;
      logic [63:0]     pd;
      logic [1:0]      pr;
      logic            pl;
      for (int i = 0; i <= len; i++) begin
         ba     = beat_addr(longint'(addr), len, size, burst, i);
         e.id   = id;
         e.last = (i == len);
         if (oor(ba)) begin
            e.data = '0;
            e.resp = 2'b11;
            e.dc   = 1'b0;
         end else begin
            widx   = int'((ba - longint'(BASE)) / 8);
            e.data = model[widx];
            e.dc   = !known[widx] || wrap_bad(len, size, burst);
            e.resp = wrap_bad(len, size, burst) ? 2'b10 : 2'b00;
         end
         rq.push_back(e);
      end
      if (!skip_ar) begin
         arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = burst;
         arvalid = 1'b1;
         t = 0;
         while (!arready && t < TMO) begin @(posedge clock); #1; t++; end
         checks++;
         if (arready !== 1'b1) begin
            errors++;
            $display("FAIL ar_handshake: arready=%b required 1 within %0d cycles", arready, TMO);
         end
         @(posedge clock); #1;
         arvalid = 1'b0;
      end
      hs = cyc; t = 0; got = 0; first = 1'b1; pstall = 1'b0;
      pd = '0; pr = '0; pl = 1'b0;
      while (got <= len && t < TMO) begin
         rready = toggle ? (t % 2 == 1) : 1'b1;
         if (rvalid) begin
            if (first) begin
               first = 1'b0;
               checks++;
               if (cyc - hs != RD_LAT) begin
                  errors++;
                  $display("FAIL rd_latency: got %0d cycles required %0d", cyc - hs, RD_LAT);
               end
            end
            if (pstall) begin
               checks++;
               if ({rdata, rresp, rlast} !== {pd, pr, pl}) begin
                  errors++;
                  $display("FAIL r_stall_stable: data=%h resp=%0d last=%b required %h %0d %b",
                           rdata, rresp, rlast, pd, pr, pl);
               end
            end
            if (rready) begin
               if (rq.size() > 0) begin
                  e = rq.pop_front();
                  if (!e.dc) begin
                     checks++;
                     if (rdata !== e.data) begin
                        errors++;
                        $display("FAIL r_data beat %0d: rdata=%h required %h", got, rdata, e.data);
                     end
                  end
                  checks++;
                  if ({rresp, rlast, rid} !== {e.resp, e.last, e.id}) begin
                     errors++;
                     $display("FAIL r_ctrl beat %0d: resp=%0d last=%b id=%0d required %0d %b %0d",
                              got, rresp, rlast, rid, e.resp, e.last, e.id);
                  end
               end
               got++;
               pstall = 1'b0;
            end else begin
               pstall = 1'b1;
               pd = rdata; pr = rresp; pl = rlast;
            end
         end
         @(posedge clock); #1;
         t++;
      end
      rready = 1'b0;
      checks++;
      if (got != len + 1) begin
         errors++;
         $display("FAIL r_beats: got %0d beats required %0d", got, len + 1);
      end
      checks++;
      if ({rvalid, arready} !== 2'b01) begin
         errors++;
         $display("FAIL r_return_idle: rvalid=%b arready=%b required 0 1", rvalid, arready);
      end
      rq.delete();
   endtask

   task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int size, input logic [1:0] burst, input int last_at,
                           input logic [7:0] strb, input int bhold);
      longint unsigned ba;
      int              nb, widx, t;
      bit              dec, slv;
      bexp_t           be;
      logic [5:0]      pb;
      nb  = (last_at >= 0) ? last_at + 1 : len + 1;
      dec = 1'b0;
      slv = wrap_bad(len, size, burst) || (last_at != len);
      for (int i = 0; i < nb; i++) begin
         ba = beat_addr(longint'(addr), len, size, burst, i);
         if (oor(ba)) dec = 1'b1;
         else begin
            widx = int'((ba - longint'(BASE)) / 8);
            for (int j = 0; j < 8; j++)
               if (strb[j]) model[widx][8*j +: 8] = wbuf[i][8*j +: 8];
            known[widx] = 1'b1;
         end
      end
      bq.push_back({id, dec ? 2'b11 : (slv ? 2'b10 : 2'b00)});
      awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = burst;
      awvalid = 1'b1;
      t = 0;
      while (!awready && t < TMO) begin @(posedge clock); #1; t++; end
      checks++;
      if (awready !== 1'b1) begin
         errors++;
         $display("FAIL aw_handshake: awready=%b required 1 within %0d cycles", awready, TMO);
      end
      @(posedge clock); #1;
      awvalid = 1'b0;
      for (int i = 0; i < nb; i++) begin
         wvalid = 1'b1; wdata = wbuf[i]; wstrb = strb; wlast = (i == last_at);
         t = 0;
         while (!wready && t < TMO) begin @(posedge clock); #1; t++; end
         checks++;
         if (wready !== 1'b1) begin
            errors++;
            $display("FAIL w_beat %0d: wready=%b required 1", i, wready);
         end
         @(posedge clock); #1;
      end
      wvalid = 1'b0; wlast = 1'b0;
      t = 0;
      while (!bvalid && t < TMO) begin @(posedge clock); #1; t++; end
      checks++;
      if (bvalid !== 1'b1) begin
         errors++;
         $display("FAIL b_valid: bvalid=%b required 1 within %0d cycles", bvalid, TMO);
      end
      pb = {bid, bresp};
      for (int k = 0; k < bhold; k++) begin
         @(posedge clock); #1;
         checks++;
         if ({bvalid, bid, bresp, awready} !== {1'b1, pb, 1'b0}) begin
            errors++;
            $display("FAIL b_stall %0d: bvalid=%b id/resp=%h awready=%b required 1 %h 0",
                     k, bvalid, {bid, bresp}, awready, pb);
         end
      end
      bready = 1'b1;
      be = bq.pop_front();
      checks++;
      if ({bid, bresp} !== {be.id, be.resp}) begin
         errors++;
         $display("FAIL b_resp: bid=%0d bresp=%0d required %0d %0d", bid, bresp, be.id, be.resp);
      end
      @(posedge clock); #1;
      bready = 1'b0;
      checks++;
      if ({bvalid, awready} !== 2'b01) begin
         errors++;
         $display("FAIL b_done: bvalid=%b awready=%b required 0 1", bvalid, awready);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      arvalid = 1'b1; arid = 4'd3; araddr = BASE; arlen = 8'd0; arsize = 3'd3; arburst = 2'b01;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock); #1;
         checks++;
         if ({awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp, rlast} !== '0) begin
            errors++;
            $display("FAIL reset_outputs cycle %0d: aw=%b w=%b b=%b ar=%b r=%b rdata=%h required all 0",
                     i, awready, wready, bvalid, arready, rvalid, rdata);
         end
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({arready, awready, wready} !== 3'b110) begin
         errors++;
         $display("FAIL reset_release: ar/aw/w ready=%b required 110", {arready, awready, wready});
      end
      @(posedge clock); #1;
      arvalid = 1'b0;
      checks++;
      if (arready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ar_accept: arready=%b required 0 after handshake", arready);
      end
      do_read(4'd3, BASE, 0, 3, 2'b01, 1'b0, 1'b1);
   endtask

   task automatic test_incr();
      wbuf[0] = 64'h1111_1111_1111_1111; wbuf[1] = 64'h2222_2222_2222_2222;
      wbuf[2] = 64'h3333_3333_3333_3333; wbuf[3] = 64'h4444_4444_4444_4444;
      do_write(4'd5, BASE, 3, 3, 2'b01, 3, 8'hFF, 0);
      do_read(4'd6, BASE, 3, 3, 2'b01, 1'b0, 1'b0);
   endtask

   task automatic test_wrap_fixed();
      do_read(4'd7, BASE + 32'h10, 3, 3, 2'b10, 1'b0, 1'b0);
      do_read(4'd8, BASE + 32'h10, 2, 3, 2'b10, 1'b0, 1'b0);
      do_read(4'd9, BASE + 32'h08, 1, 3, 2'b00, 1'b0, 1'b0);
   endtask

   task automatic test_narrow();
      wbuf[0] = 64'hFFFF_FFFF_ABFF_FFFF;
      do_write(4'd1, BASE + 32'h3, 0, 0, 2'b01, 0, 8'h08, 0);
      do_read(4'd2, BASE, 0, 3, 2'b01, 1'b0, 1'b0);
   endtask

   task automatic test_errors();
      do_read(4'd3, BASE + 32'(DEPTH * 8), 0, 3, 2'b01, 1'b0, 1'b0);
      wbuf[0] = 64'hDEAD_BEEF_DEAD_BEEF;
      do_write(4'd4, BASE + 32'(DEPTH * 8), 0, 3, 2'b01, 0, 8'hFF, 0);
      do_read(4'd5, BASE, 0, 3, 2'b01, 1'b0, 1'b0);
      wbuf[0] = 64'h0123_4567_89AB_CDEF; wbuf[1] = 64'hFEDC_BA98_7654_3210;
      do_write(4'd6, BASE + 32'(DEPTH * 8 - 8), 1, 3, 2'b01, 1, 8'hFF, 0);
      do_read(4'd7, BASE + 32'(DEPTH * 8 - 8), 1, 3, 2'b01, 1'b0, 1'b0);
      wbuf[0] = 64'hAAAA_0000_AAAA_0000; wbuf[1] = 64'hBBBB_0000_BBBB_0000;
      do_write(4'd8, BASE + 32'h40, 3, 3, 2'b01, 1, 8'hFF, 0);
      do_write(4'd9, BASE + 32'h60, 1, 3, 2'b01, -1, 8'hFF, 0);
      do_read(4'd10, BASE + 32'h40, 1, 3, 2'b01, 1'b0, 1'b0);
      do_read(4'd11, BASE + 32'h60, 1, 3, 2'b01, 1'b0, 1'b0);
   endtask

   task automatic test_stall();
      wbuf[0] = 64'h5555_0001_5555_0001; wbuf[1] = 64'h6666_0002_6666_0002;
      wbuf[2] = 64'h7777_0003_7777_0003; wbuf[3] = 64'h8888_0004_8888_0004;
      do_write(4'd12, BASE + 32'h20, 3, 3, 2'b01, 3, 8'hFF, 5);
      do_read(4'd13, BASE + 32'h20, 3, 3, 2'b01, 1'b1, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      awvalid = 1'b0; awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
      wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b0;
      arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
      rready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin model[i] = '0; known[i] = 1'b0; end
      test_reset();
      test_incr();
      test_wrap_fixed();
      test_narrow();
      test_errors();
      test_stall();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end
endmodule
